// File: rtl/lzc_pkg.sv
// Shared constants and sizing helper for the leading-zero-count tree.
// Every tree level imports this so index widths are derived in one place.
package lzc_pkg;

    localparam int XLEN = 256;
    localparam int XLOG = 8;

    // log2 of the supported power-of-two operand sizes
    function automatic int lzc_width(input int size);
        int w;
        case (size)
            4:       w = 2;
            8:       w = 3;
            16:      w = 4;
            32:      w = 5;
            64:      w = 6;
            128:     w = 7;
            256:     w = 8;
            default: w = 0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lzc_256_tree.sv
// Balanced tree levels of the highest-set-bit finder, from the 4-bit leaf
// up to 128 bits. Each level merges an upper and a lower half of equal width.
import lzc_pkg::*;

module lzc_4 (
    input  logic [3:0] a,
    output logic [1:0] c,
    output logic       v
);
    always_comb begin
        c = 2'd0;
        if (a[3])      c = 2'd3;
        else if (a[2]) c = 2'd2;
        else if (a[1]) c = 2'd1;
        v = |a;
    end
endmodule

module lzc_8 (
    input  logic [7:0] a,
    output logic [2:0] c,
    output logic       v
);
    localparam int CW = lzc_width(8);
    logic [CW-2:0] cs [2];
    logic          vs [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        lzc_4 u_half (.a(a[gi*4 +: 4]), .c(cs[gi]), .v(vs[gi]));
    end

    assign v = vs[1] | vs[0];
    assign c = vs[1] ? {1'b1, cs[1]} : {1'b0, cs[0]};
endmodule

module lzc_16 (
    input  logic [15:0] a,
    output logic [3:0]  c,
    output logic        v
);
    localparam int CW = lzc_width(16);
    logic [CW-2:0] cs [2];
    logic          vs [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        lzc_8 u_half (.a(a[gi*8 +: 8]), .c(cs[gi]), .v(vs[gi]));
    end

    assign v = vs[1] | vs[0];
    assign c = vs[1] ? {1'b1, cs[1]} : {1'b0, cs[0]};
endmodule

module lzc_32 (
    input  logic [31:0] a,
    output logic [4:0]  c,
    output logic        v
);
    localparam int CW = lzc_width(32);
    logic [CW-2:0] cs [2];
    logic          vs [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        lzc_16 u_half (.a(a[gi*16 +: 16]), .c(cs[gi]), .v(vs[gi]));
    end

    assign v = vs[1] | vs[0];
    assign c = vs[1] ? {1'b1, cs[1]} : {1'b0, cs[0]};
endmodule

module lzc_64 (
    input  logic [63:0] a,
    output logic [5:0]  c,
    output logic        v
);
    localparam int CW = lzc_width(64);
    logic [CW-2:0] cs [2];
    logic          vs [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        lzc_32 u_half (.a(a[gi*32 +: 32]), .c(cs[gi]), .v(vs[gi]));
    end

    assign v = vs[1] | vs[0];
    assign c = vs[1] ? {1'b1, cs[1]} : {1'b0, cs[0]};
endmodule

module lzc_128 (
    input  logic [127:0] a,
    output logic [6:0]   c,
    output logic         v
);
    localparam int CW = lzc_width(128);
    logic [CW-2:0] cs [2];
    logic          vs [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        lzc_64 u_half (.a(a[gi*64 +: 64]), .c(cs[gi]), .v(vs[gi]));
    end

    assign v = vs[1] | vs[0];
    assign c = vs[1] ? {1'b1, cs[1]} : {1'b0, cs[0]};
endmodule

// File: rtl/lzc_256.sv
// 256-bit highest-set-bit index (c = ~lzc(a)) with valid flag.
// Purely combinational; clock and reset exist only for interface uniformity.
import lzc_pkg::*;

module lzc_256 (
    input  logic            clock,
    input  logic            reset,
    input  logic [XLEN-1:0] a,
    output logic [XLOG-1:0] c,
    output logic            v
);
    localparam int HALF = XLEN / 2;

    logic [XLOG-2:0] cs [2];
    logic            vs [2];

    // Clock and reset intentionally have no effect on the result.
    logic unused_clk_rst;
    assign unused_clk_rst = clock ^ reset;

    for (genvar gi = 0; gi < 2; gi++) begin : g_half
        lzc_128 u_half (.a(a[gi*HALF +: HALF]), .c(cs[gi]), .v(vs[gi]));
    end

    assign v = vs[1] | vs[0];
    assign c = vs[1] ? {1'b1, cs[1]} : {1'b0, cs[0]};
endmodule

// File: tb/tb_lzc_256.sv
// Directed and random checks of lzc_256 against a behavioural bit-scan model.
module tb_lzc_256;

    typedef struct packed {
        logic [7:0] c;
        logic       v;
    } exp_t;

    logic         clock;
    logic         reset;
    logic [255:0] a;
    logic [7:0]   c;
    logic         v;

    exp_t exp_q [$];
    int   total;
    int   bad;

    lzc_256 dut (
        .clock(clock),
        .reset(reset),
        .a    (a),
        .c    (c),
        .v    (v)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic exp_t model(input logic [255:0] x);
        exp_t e;
        e = '0;
        for (int i = 0; i < 256; i++) begin
            if (x[i]) begin
                e.c = i[7:0];
                e.v = 1'b1;
            end
        end
        return e;
    endfunction

    // Drive an operand on the rising edge, check mid-cycle on the falling edge.
    task automatic step(input logic [255:0] val, input string tag);
        exp_t e;
        @(posedge clock);
        a = val;
        exp_q.push_back(model(val));
        @(negedge clock);
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            assert (c === e.c && v === e.v) else begin
                bad++;
                $error("FAIL %s c=%0d v=%0b expected c=%0d v=%0b", tag, c, v, e.c, e.v);
            end
        end
        $display("step %s reset=%0b c=%0d v=%0b", tag, reset, c, v);
    endtask

    // Check against a hand-written constant independent of the model.
    task automatic check_const(input logic [7:0] ec, input logic ev, input string tag);
        total++;
        assert (c === ec && v === ev) else begin
            bad++;
            $error("FAIL %s c=%0d v=%0b expected c=%0d v=%0b", tag, c, v, ec, ev);
        end
    endtask

    initial begin
        logic [255:0] x;
        logic [7:0]   inv;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        a     = '0;

        // Walking one, with reset high for the first two cycles
        x = 256'd1;
        step(x, "walk_rst0");
        check_const(8'd0, 1'b1, "walk_rst0_const");
        step(x, "walk_rst1");
        reset = 1'b0;
        for (int i = 0; i < 256; i++) begin
            x = 256'd1 << i;
            step(x, "walk");
            inv = 8'(255 - i);
            total++;
            assert (c === ~inv) else begin
                bad++;
                $error("FAIL walk_inv i=%0d c=%0d expected %0d", i, c, ~inv);
            end
        end
        check_const(8'd255, 1'b1, "walk_top");

        // Zero and all ones
        step('0, "zero");
        check_const(8'd0, 1'b0, "zero_const");
        step({256{1'b1}}, "ones");
        check_const(8'd255, 1'b1, "ones_const");

        // Lower bits below the leading one must not matter
        for (int n = 0; n < 1000; n++) begin
            x = '0;
            x[100] = 1'b1;
            for (int k = 0; k < 100; k++) x[k] = 1'($urandom_range(0, 1));
            step(x, "mask100");
            if (n < 3) check_const(8'd100, 1'b1, "mask100_const");
        end

        // Reset asserted and released around a steady operand
        @(posedge clock);
        reset = 1'b1;
        a = 256'd1 << 17;
        @(negedge clock);
        check_const(8'd17, 1'b1, "rst_hi_17");
        @(posedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_const(8'd17, 1'b1, "rst_lo_17");

        // Half boundary
        step(256'd1 << 127, "half127");
        check_const(8'd127, 1'b1, "half127_const");
        step(256'd1 << 128, "half128");
        check_const(8'd128, 1'b1, "half128_const");
        step((256'd1 << 127) | (256'd1 << 128), "half_both");
        check_const(8'd128, 1'b1, "half_both_const");

        // Random full-width operands, random sparse operands, reset toggling
        for (int n = 0; n < 40; n++) begin
            for (int w = 0; w < 8; w++) x[w*32 +: 32] = $urandom;
            if (n % 2 == 1) x = x >> $urandom_range(0, 255);
            reset = 1'(n % 3 == 0);
            step(x, "random");
        end
        reset = 1'b0;

        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_leftover size=%0d expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lzc_256.md
LZC_256 -- requirements
Module: lzc_256

Interface
REQ-001 Parameter: XLEN, 256, input vector width (fixed; localparam).
REQ-002 Parameter: XLOG, 8, output index width = log2(XLEN) (fixed; localparam).
REQ-003 Port: clock  input  1  clock; clock clock.
REQ-004 Port: reset  input  1  reset; reset reset, synchronous, active-high.
REQ-005 Port: a  input  256  operand to scan.
REQ-006 Port: c  output  8  bit index of the most-significant set bit of a; equals bitwise-inverted leading-zero count, ~lzc(a).
REQ-007 Port: v  output  1  valid; high when a has at least one set bit.

Function
REQ-008 The block SHALL be purely combinational from a to c and v, with zero-cycle latency: c and v settle within the same cycle a changes.
REQ-009 For a != 0, c SHALL equal the index i of the highest set bit, such that a[i]=1 and a[255:i+1]=0.
REQ-010 Equivalently, c SHALL equal 255 minus the number of leading zeros; a=1 gives c=0, and a=2^255 gives c=255.
REQ-011 Bits of a below the highest set bit SHALL NOT affect c.
REQ-012 For a != 0, v SHALL be 1.
REQ-013 For a == 0, v SHALL be 0 and c SHALL be 8'd0.
REQ-014 No handshake SHALL exist; there is no enable, no stall, and no registered output.
REQ-015 Arithmetic: c is unsigned, 8 bits, and SHALL never exceed 255; no wrap-around is possible.
REQ-016 The implementation SHALL be a balanced binary tree. Each merge node takes the upper half (ch, vh) and the lower half (cl, vl) and produces v = vh | vl and c = vh ? {1'b1, ch} : {1'b0, cl}.
REQ-017 The leaf SHALL be a 4-bit priority encoder:
- a[3] gives c=3; else a[2] gives c=2; else a[1] gives c=1; else a[0] gives c=0.
- v = |a.
- c = 0 when all four bits are 0.
REQ-018 Combinational depth SHALL be O(log2 XLEN) merge levels; no linear priority chain across the full 256 bits.

Reset
REQ-019 The block SHALL contain no state; clock and reset are present for interface uniformity and SHALL NOT gate or alter c and v.
REQ-020 While reset=1, c and v SHALL still reflect the current value of a, identical to their behaviour with reset=0.
REQ-021 Asserting or deasserting reset mid-operation SHALL cause no output glitch attributable to reset and no change in latency.

Structure
REQ-022 A shared package lzc_pkg SHALL hold the constants XLEN=256 and XLOG=8, plus a width function giving log2 of any supported size (4, 8, 16, 32, 64, 128, 256).
REQ-023 lzc_256 SHALL instantiate two copies of the natural sub-module lzc_128, one on a[255:128] and one on a[127:0], and merge them per REQ-016.
REQ-024 lzc_128 SHALL in turn be built recursively down to a lzc_4 leaf, with identical port semantics (a, c, v) at every level.
REQ-025 The sizes 128 and 16 SHALL be independently usable modules with the same contract at their own widths.

Verification
REQ-026 Walking one: reset high for 2 cycles with a=1, then a shifts left once per cycle for 256 cycles -> every cycle c equals the index of the set bit (0..255), v=1, and c == ~(255-i) at step i; PASS when a reaches 2^255.
REQ-027 Zero input: a=0 -> v=0, c=0.
REQ-028 All ones: a={256{1'b1}} -> c=255, v=1.
REQ-029 Masking of lower bits: a has bit 100 set and random bits in 99:0 (bits 255:101 zero) -> c=100, v=1, for 1000 random lower patterns.
REQ-030 Reset independence: reset=1 with a=2^17 -> c=17, v=1 in the same cycle; deassert reset -> outputs unchanged.
REQ-031 Half boundary: a=2^127 -> c=127; a=2^128 -> c=128; a=2^127|2^128 -> c=128; v=1 in all three cases.
